pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch/execute control FSM that sequences program_counter: decides each instruction's PC update and drives pc_enable, pc_sel, target_addr.
//  Owns the hardware return-address stack for CALL/RET and resolves BEQ/BNE from the ALU zero flag.
//  Sits between the instruction decoder/ALU and program_counter; reports HALT and stack faults to top level.
// PARAMETERS
//  ADDR_W       16  PC / target address width
//  STACK_DEPTH   8  return-address stack entries (power of 2, >=2)
// PORTS
//  clk             in   1       system clock, rising edge
//  reset_n         in   1       asynchronous active-low reset
//  pc_in           in   ADDR_W  current PC value from program_counter
//  instr_valid     in   1       decoder presents a valid instruction this cycle
//  op_class        in   3       000 ALU/NOP, 001 JMP, 010 CALL, 011 RET, 100 BEQ, 101 BNE, 110 HALT, 111 rsvd(=NOP)
//  imm_addr        in   ADDR_W  jump/call/branch target from instruction
//  zero_flag       in   1       ALU zero flag, valid in EXEC cycle
//  stall           in   1       hold current state; no PC update, no stack change
//  pc_enable       out  1       enable to program_counter
//  pc_sel          out  2       00 PC+1, 01 JMP/CALL, 10 branch, 11 RET
//  target_addr     out  ADDR_W  target to program_counter
//  halted          out  1       high in HALTED state
//  fault           out  1       sticky: stack overflow or underflow
//  stack_depth     out  log2(STACK_DEPTH)+1  entries in use
// BEHAVIOUR
//  Reset (async, reset_n=0): state=FETCH, sp=0, op regs=0; pc_enable=0, pc_sel=00, target_addr=0, halted=0, fault=0, stack_depth=0.
//  Deassertion: first active edge after reset_n rises is a normal FETCH cycle.
//  States: FETCH, EXEC, HALTED, FAULT (encoding free).
//  FETCH: if instr_valid && !stall -> latch op_class, imm_addr; go EXEC. Else stay. pc_enable=0.
//  EXEC (one cycle unless stalled): if stall -> stay EXEC, pc_enable=0, stack untouched.
//   Else, by latched op_class; pc_enable=1 for exactly this cycle, next state FETCH:
//   ALU/NOP/rsvd: pc_sel=00.
//   JMP: pc_sel=01, target=imm.
//   CALL: stack not full -> push pc_in+1 (mod 2^ADDR_W), pc_sel=01, target=imm.
//   RET: stack not empty -> pop, pc_sel=11, target=popped value.
//   BEQ: zero_flag=1 -> pc_sel=10, target=imm; else pc_sel=00.
//   BNE: zero_flag=0 -> pc_sel=10, target=imm; else pc_sel=00.
//   HALT: pc_enable=0, -> HALTED.
//   CALL with stack full / RET with stack empty: pc_enable=0, no push/pop, fault<=1, -> FAULT.
//  pc_enable, pc_sel, target_addr combinational from state, latched op, stack top, zero_flag, stall; pc_sel=00, target_addr=0 whenever pc_enable=0.
//  Latency: one PC update per instruction, 2 cycles/instr min (FETCH+EXEC); new PC visible in FETCH after EXEC.
//  Stack: LIFO, full when stack_depth==STACK_DEPTH, empty when 0; contents not cleared by reset (sp reset only).
//  HALTED, FAULT: terminal; all inputs ignored; exit only via reset_n. fault stays 1 in FAULT.
//  pc_in+1 wraps: 16'hFFFF -> push 16'h0000.
//  instr_valid ignored outside FETCH; stall ignored in HALTED/FAULT.
// TESTING
//  Reset, then 3 NOPs with instr_valid=1 -> pc_enable pulses every 2nd cycle, pc_sel=00, stack_depth=0.
//  CALL imm=0x0040 at pc_in=0x0010, then RET -> sel 01/target 0x0040, depth 1; then sel 11/target 0x0011, depth 0.
//  9 nested CALLs (DEPTH=8) -> 9th: pc_enable=0, fault=1, FAULT; RET on empty after reset -> fault=1.
//  BEQ imm=0x0100 with zero=1 -> sel 10/0x0100; zero=0 -> sel 00; BNE mirrored.
//  stall=1 for 3 cycles in EXEC of JMP -> no pc_enable, no stack change; on release sel 01 once.
//  reset_n low mid-EXEC of CALL -> outputs 0 immediately, depth 0; HALT -> halted=1, further instr ignored.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle between the decoder/ALU/program_counter side and the PC sequencer.
// The master modport is the surrounding datapath; the slave modport is the sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0]  pc_in;
  logic               instr_valid;
  logic [2:0]         op_class;
  logic [ADDR_W-1:0]  imm_addr;
  logic               zero_flag;
  logic               stall;
  logic               pc_enable;
  logic [1:0]         pc_sel;
  logic [ADDR_W-1:0]  target_addr;
  logic               halted;
  logic               fault;
  logic [DEPTH_W-1:0] stack_depth;

  modport master (
    output pc_in, instr_valid, op_class, imm_addr, zero_flag, stall,
    input  pc_enable, pc_sel, target_addr, halted, fault, stack_depth
  );

  modport slave (
    input  pc_in, instr_valid, op_class, imm_addr, zero_flag, stall,
    output pc_enable, pc_sel, target_addr, halted, fault, stack_depth
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for program_counter: one PC update per instruction,
// hardware return-address stack for CALL/RET, BEQ/BNE resolved from the ALU zero flag.
// HALTED and FAULT are terminal until reset_n.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  FETCH   | wait for a valid, unstalled instruction; latch op and target
//  EXEC    | apply the latched op to the PC (one cycle unless stalled)
//  HALTED  | HALT executed; inputs ignored
//  FAULT   | CALL on full stack or RET on empty stack; inputs ignored
//
// ADDR_W / STACK_DEPTH must match the parameters of the connected interface.
module pc_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_sequencer_if.slave   bus
);

  localparam int IDX_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = IDX_W + 1;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  localparam logic [1:0] SEL_INC  = 2'b00;
  localparam logic [1:0] SEL_JMP  = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_RET  = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic [ADDR_W-1:0]  imm_q;
  logic [DEPTH_W-1:0] sp;
  logic               fault_q;
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

  logic               latch_op;
  logic               push;
  logic               pop;
  logic               set_fault;
  logic               pc_enable;
  logic [1:0]         pc_sel;
  logic [ADDR_W-1:0]  target_addr;

  logic               stack_full;
  logic               stack_empty;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   top_idx;

  assign stack_full  = (sp == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = sp[IDX_W-1:0];
  assign top_idx     = sp[IDX_W-1:0] - IDX_W'(1);

  // State register, latched instruction fields, stack pointer and sticky fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      op_q    <= '0;
      imm_q   <= '0;
      sp      <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_op) begin
        op_q  <= bus.op_class;
        imm_q <= bus.imm_addr;
      end
      if (push) begin
        sp <= sp + DEPTH_W'(1);
      end else if (pop) begin
        sp <= sp - DEPTH_W'(1);
      end
      if (set_fault) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Return-address storage; only the pointer is reset, contents are left as-is.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= bus.pc_in + ADDR_W'(1);
    end
  end

  // Next-state decode and PC-update outputs; everything idles at zero unless EXEC commits.
  always_comb begin
    state_nxt   = state;
    latch_op    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    set_fault   = 1'b0;
    pc_enable   = 1'b0;
    pc_sel      = SEL_INC;
    target_addr = '0;
    case (state)
      S_FETCH: begin
        if (bus.instr_valid && !bus.stall) begin
          latch_op  = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!bus.stall) begin
          state_nxt = S_FETCH;
          pc_enable = 1'b1;
          case (op_q)
            OP_JMP: begin
              pc_sel      = SEL_JMP;
              target_addr = imm_q;
            end
            OP_CALL: begin
              if (stack_full) begin
                pc_enable = 1'b0;
                set_fault = 1'b1;
                state_nxt = S_FAULT;
              end else begin
                push        = 1'b1;
                pc_sel      = SEL_JMP;
                target_addr = imm_q;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                pc_enable = 1'b0;
                set_fault = 1'b1;
                state_nxt = S_FAULT;
              end else begin
                pop         = 1'b1;
                pc_sel      = SEL_RET;
                target_addr = stack_mem[top_idx];
              end
            end
            OP_BEQ: begin
              if (bus.zero_flag) begin
                pc_sel      = SEL_BR;
                target_addr = imm_q;
              end
            end
            OP_BNE: begin
              if (!bus.zero_flag) begin
                pc_sel      = SEL_BR;
                target_addr = imm_q;
              end
            end
            OP_HALT: begin
              pc_enable = 1'b0;
              state_nxt = S_HALTED;
            end
            default: begin
              pc_sel = SEL_INC;
            end
          endcase
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  assign bus.pc_enable   = pc_enable;
  assign bus.pc_sel      = pc_sel;
  assign bus.target_addr = target_addr;
  assign bus.halted      = (state == S_HALTED);
  assign bus.fault       = fault_q;
  assign bus.stack_depth = sp;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a driver issues instructions and pushes the expected
// PC update (from a queue-based model of the stack and PC) into a scoreboard;
// a monitor pops and compares on every pc_enable pulse.
module tb_pc_sequencer;

  localparam int ADDR_W      = 16;
  localparam int STACK_DEPTH = 8;

  localparam int OP_ALU  = 0;
  localparam int OP_JMP  = 1;
  localparam int OP_CALL = 2;
  localparam int OP_RET  = 3;
  localparam int OP_BEQ  = 4;
  localparam int OP_BNE  = 5;
  localparam int OP_HALT = 6;
  localparam int OP_RSVD = 7;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] target;
    int          depth;
  } exp_t;

  logic clk;
  logic reset_n;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  exp_t        exp_q[$];
  logic [15:0] ref_stack[$];
  logic [15:0] ref_pc;
  bit          ref_halt;
  bit          ref_fault;

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation; idle cycles must show zero sel/target.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.pc_enable === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got sel=%0d target=%0h with no expected update at %0t",
                   bus.pc_sel, bus.target_addr, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.pc_sel !== e.sel || bus.target_addr !== e.target ||
              int'(bus.stack_depth) != e.depth) begin
            errors++;
            $display("FAIL pulse: got sel=%0d target=%0h depth=%0d expected sel=%0d target=%0h depth=%0d at %0t",
                     bus.pc_sel, bus.target_addr, bus.stack_depth, e.sel, e.target, e.depth, $time);
          end
        end
      end else begin
        checks++;
        if (bus.pc_sel !== 2'b00 || bus.target_addr !== 16'h0000) begin
          errors++;
          $display("FAIL idle_outputs: got sel=%0d target=%0h expected 0/0 at %0t",
                   bus.pc_sel, bus.target_addr, $time);
        end
      end
    end
  end

  task automatic set_pc(input logic [15:0] v);
    ref_pc    = v;
    bus.pc_in = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_enable"},   32'(bus.pc_enable),   32'd0);
    chk({tag, "_pc_sel"},      32'(bus.pc_sel),      32'd0);
    chk({tag, "_target"},      32'(bus.target_addr), 32'd0);
    chk({tag, "_halted"},      32'(bus.halted),      32'd0);
    chk({tag, "_fault"},       32'(bus.fault),       32'd0);
    chk({tag, "_stack_depth"}, 32'(bus.stack_depth), 32'd0);
  endtask

  // Called just after a rising edge; asserts reset, checks the async clear, releases on a falling edge.
  task automatic do_reset();
    reset_n         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.stall       = 1'b0;
    #1;
    check_reset_outputs("reset");
    ref_stack.delete();
    exp_q.delete();
    ref_halt  = 1'b0;
    ref_fault = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction (called just after a rising edge, DUT in FETCH or terminal).
  task automatic issue(input int op, input logic [15:0] imm, input logic zero, input int stall_n);
    exp_t e;
    bit   pulse;
    int   depth_before;
    pulse        = 1'b0;
    depth_before = ref_stack.size();
    e.depth      = depth_before;
    e.sel        = 2'b00;
    e.target     = 16'h0000;
    if (!ref_halt && !ref_fault) begin
      case (op)
        OP_JMP: begin
          pulse = 1'b1; e.sel = 2'b01; e.target = imm; ref_pc = imm;
        end
        OP_CALL: begin
          if (ref_stack.size() == STACK_DEPTH) begin
            ref_fault = 1'b1;
          end else begin
            ref_stack.push_back(ref_pc + 16'd1);
            pulse = 1'b1; e.sel = 2'b01; e.target = imm; ref_pc = imm;
          end
        end
        OP_RET: begin
          if (ref_stack.size() == 0) begin
            ref_fault = 1'b1;
          end else begin
            pulse = 1'b1; e.sel = 2'b11; e.target = ref_stack.pop_back(); ref_pc = e.target;
          end
        end
        OP_BEQ, OP_BNE: begin
          pulse = 1'b1;
          if ((op == OP_BEQ) == (zero == 1'b1)) begin
            e.sel = 2'b10; e.target = imm; ref_pc = imm;
          end else begin
            ref_pc = ref_pc + 16'd1;
          end
        end
        OP_HALT: ref_halt = 1'b1;
        default: begin
          pulse = 1'b1; ref_pc = ref_pc + 16'd1;
        end
      endcase
    end
    if (pulse) exp_q.push_back(e);

    bus.instr_valid = 1'b1;
    bus.op_class    = 3'(op);
    bus.imm_addr    = imm;
    bus.zero_flag   = zero;
    bus.stall       = 1'b0;
    @(posedge clk);
    #1;
    // Scramble the decoder fields during EXEC so only the latched copy can be used.
    bus.instr_valid = 1'b0;
    bus.op_class    = 3'($urandom);
    bus.imm_addr    = 16'($urandom);
    bus.stall       = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      @(posedge clk);
      #1;
      chk("stall_depth", 32'(bus.stack_depth), 32'(depth_before));
    end
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    bus.pc_in = ref_pc;
    chk("pulse_count",  32'(exp_q.size()),   32'd0);
    chk("stack_depth",  32'(bus.stack_depth), 32'(ref_stack.size()));
    chk("halted",       32'(bus.halted),      32'(ref_halt));
    chk("fault",        32'(bus.fault),       32'(ref_fault));
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.pc_in       = '0;
    bus.instr_valid = 1'b0;
    bus.op_class    = '0;
    bus.imm_addr    = '0;
    bus.zero_flag   = 1'b0;
    bus.stall       = 1'b0;
    ref_pc          = '0;
    ref_halt        = 1'b0;
    ref_fault       = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three NOPs: one pc_sel=00 pulse per two-cycle instruction.
    set_pc(16'h0000);
    for (int i = 0; i < 3; i++) issue(OP_ALU, 16'h1234, 1'b0, 0);

    // CALL then RET.
    set_pc(16'h0010);
    issue(OP_CALL, 16'h0040, 1'b0, 0);
    issue(OP_RET,  16'h0000, 1'b0, 0);

    // BEQ / BNE taken and not taken, plus reserved opcode as NOP.
    issue(OP_BEQ, 16'h0100, 1'b1, 0);
    issue(OP_BEQ, 16'h0100, 1'b0, 0);
    issue(OP_BNE, 16'h0200, 1'b0, 0);
    issue(OP_BNE, 16'h0200, 1'b1, 0);
    issue(OP_RSVD, 16'h0300, 1'b0, 0);

    // JMP held in EXEC by a three-cycle stall, and a stalled CALL.
    issue(OP_JMP,  16'h0ABC, 1'b0, 3);
    issue(OP_CALL, 16'h0500, 1'b0, 2);
    issue(OP_RET,  16'h0000, 1'b0, 1);

    // Return address wraps from 0xFFFF to 0x0000.
    set_pc(16'hFFFF);
    issue(OP_CALL, 16'h0020, 1'b0, 0);
    issue(OP_RET,  16'h0000, 1'b0, 0);

    // Nine nested CALLs: the ninth faults; FAULT then ignores input.
    do_reset();
    set_pc(16'h0100);
    for (int i = 0; i < 9; i++) issue(OP_CALL, 16'(16'h0200 + i * 16), 1'b0, 0);
    issue(OP_RET, 16'h0000, 1'b0, 0);
    issue(OP_ALU, 16'h0000, 1'b0, 0);

    // RET on an empty stack right after reset.
    do_reset();
    issue(OP_RET, 16'h0000, 1'b0, 0);

    // Reset asserted in the middle of a CALL's EXEC cycle.
    do_reset();
    set_pc(16'h0030);
    issue(OP_CALL, 16'h0060, 1'b0, 0);
    issue(OP_CALL, 16'h0070, 1'b0, 0);
    bus.instr_valid = 1'b1;
    bus.op_class    = 3'(OP_CALL);
    bus.imm_addr    = 16'h0080;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    chk("exec_before_reset", 32'(bus.pc_enable), 32'd1);
    do_reset();

    // HALT, then further instructions are ignored.
    set_pc(16'h0000);
    issue(OP_ALU,  16'h0000, 1'b0, 0);
    issue(OP_HALT, 16'h0000, 1'b0, 0);
    issue(OP_JMP,  16'h0F00, 1'b0, 0);
    issue(OP_CALL, 16'h0F00, 1'b0, 1);
    do_reset();

    // Randomized instruction stream; recover with reset after HALT/FAULT.
    set_pc(16'($urandom));
    for (int n = 0; n < 300; n++) begin
      int r;
      int op;
      int st;
      r  = int'($urandom_range(0, 15));
      op = (r <= 2)  ? OP_ALU  :
           (r == 3)  ? OP_RSVD :
           (r <= 5)  ? OP_JMP  :
           (r <= 8)  ? OP_CALL :
           (r <= 10) ? OP_RET  :
           (r <= 12) ? OP_BEQ  :
           (r <= 14) ? OP_BNE  : OP_HALT;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(op, 16'($urandom), 1'($urandom), st);
      if (ref_halt || ref_fault) begin
        issue(OP_JMP, 16'($urandom), 1'b0, 0);
        do_reset();
        set_pc(16'($urandom));
      end
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
